// File: rtl/nf10_output_demux.sv
// nf10_output_demux: routes each 256-bit AXI4-Stream packet to any subset of three outputs by the tuser destination mask
module nf10_output_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DST_PORT_POS       = 24
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                              m_axis_tlast_0,
  output logic                              m_axis_tvalid_0,
  input  logic                              m_axis_tready_0,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                              m_axis_tlast_1,
  output logic                              m_axis_tvalid_1,
  input  logic                              m_axis_tready_1,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                              m_axis_tlast_2,
  output logic                              m_axis_tvalid_2,
  input  logic                              m_axis_tready_2,
  output logic [31:0]                       pkt_drop_count
);
  typedef enum logic [1:0] {SOP, BODY, DROP} state_t;
  state_t                            r_state, w_next;
  logic [2:0]                        r_valid, r_mask, w_ready, w_mask, w_sel;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    r_data;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  r_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   r_user;
  logic                              r_last;
  logic [31:0]                       r_drop_count;
  logic                              w_slot_free, w_tready, w_load, w_drop;
  assign w_ready     = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
  assign w_mask      = s_axis_tuser[C_DST_PORT_POS +: 3];
  assign w_slot_free = &(~r_valid | w_ready);
  // next state, input ready, and load/drop strobes; zero-mask and DROP beats never wait on outputs
  always_comb begin
    w_next   = r_state;
    w_tready = 1'b0;
    w_load   = 1'b0;
    w_drop   = 1'b0;
    w_sel    = r_mask;
    case (r_state)
      SOP: begin
        w_sel    = w_mask;
        w_tready = (w_mask == 3'b000) | w_slot_free;
        if (s_axis_tvalid && w_tready) begin
          w_drop = w_mask == 3'b000;
          w_load = w_mask != 3'b000;
          w_next = s_axis_tlast ? SOP : (w_mask == 3'b000 ? DROP : BODY);
        end
      end
      BODY: begin
        w_tready = w_slot_free;
        w_load   = s_axis_tvalid & w_slot_free;
        w_next   = (w_load && s_axis_tlast) ? SOP : BODY;
      end
      DROP: begin
        w_tready = 1'b1;
        w_next   = (s_axis_tvalid && s_axis_tlast) ? SOP : DROP;
      end
      default: w_next = SOP;
    endcase
  end
  assign s_axis_tready = w_tready & ~axi_reset;
  // packet state and the destination mask latched from the first beat
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state <= SOP;
      r_mask  <= 3'b000;
    end else begin
      r_state <= w_next;
      r_mask  <= w_load ? w_sel : r_mask;
    end
  end
  // per-output valids drain independently so a multicast beat is taken once per port
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) r_valid <= 3'b000;
    else           r_valid <= w_load ? w_sel : (r_valid & ~w_ready);
  end
  // shared output register, held stable until every selected port has taken it
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_data <= '0;
      r_strb <= '0;
      r_user <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= s_axis_tdata;
      r_strb <= s_axis_tstrb;
      r_user <= s_axis_tuser;
      r_last <= s_axis_tlast;
    end
  end
  // saturating count of zero-mask packets, bumped on their first beat only
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset)                   r_drop_count <= '0;
    else if (w_drop && ~&r_drop_count) r_drop_count <= r_drop_count + 32'd1;
  end
  assign pkt_drop_count  = r_drop_count;
  assign m_axis_tvalid_0 = r_valid[0];
  assign m_axis_tvalid_1 = r_valid[1];
  assign m_axis_tvalid_2 = r_valid[2];
  assign m_axis_tdata_0  = r_data;
  assign m_axis_tdata_1  = r_data;
  assign m_axis_tdata_2  = r_data;
  assign m_axis_tstrb_0  = r_strb;
  assign m_axis_tstrb_1  = r_strb;
  assign m_axis_tstrb_2  = r_strb;
  assign m_axis_tuser_0  = r_user;
  assign m_axis_tuser_1  = r_user;
  assign m_axis_tuser_2  = r_user;
  assign m_axis_tlast_0  = r_last;
  assign m_axis_tlast_1  = r_last;
  assign m_axis_tlast_2  = r_last;
endmodule

// File: doc/nf10_output_demux.md
Name: nf10_output_demux

Overview:
- Splits one 256-bit AXI4-Stream into three output streams; the mirror of the input arbiter, sitting after the datapath lookup and before the port/DMA egress interfaces.
- Routes each packet by the one-hot destination mask that the first beat carries in tuser.
- Supports unicast and multicast (any mask combination); drops and counts packets whose mask is zero.
- One-beat registered output stage, full throughput.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master tdata width (tstrb = width/8)
C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master width
C_M_AXIS_TUSER_WIDTH, 128, master tuser width
C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master width
C_DST_PORT_POS, 24, LSB of the 3-bit destination mask field in tuser; bit i selects output i

Ports:
axi_aclk  in  1  clock; all logic rising-edge
axi_reset  in  1  asynchronous, active-high reset
s_axis_tdata  in  256  input data
s_axis_tstrb  in  32  input byte strobes
s_axis_tuser  in  128  input sideband; destination mask valid on the first beat only
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of packet
m_axis_tdata_i / m_axis_tstrb_i / m_axis_tuser_i / m_axis_tlast_i  out  256/32/128/1  output i, for i = 0,1,2; the three outputs share the same register
m_axis_tvalid_i  out  1  per-output valid (i = 0,1,2)
m_axis_tready_i  in  1  per-output ready (i = 0,1,2)
pkt_drop_count  out  32  number of packets dropped for a zero mask; saturating

Behaviour:
- Reset (asynchronous, while axi_reset=1):
  - all m_axis_tvalid_i=0; shared data/strb/user/last registers=0
  - pkt_drop_count=0; state=SOP; cur_mask=0; s_axis_tready=0
- slot_free = AND over i of (!m_axis_tvalid_i | m_axis_tready_i).
- A beat is accepted when s_axis_tvalid & s_axis_tready.
- State SOP:
  - mask = s_axis_tuser[C_DST_PORT_POS+2:C_DST_PORT_POS]; other tuser bits are ignored for routing.
  - If mask=0: s_axis_tready=1 regardless of slot_free. The beat is discarded and pkt_drop_count increments once per packet, saturating at 0xFFFFFFFF. Next state: SOP if tlast, else DROP.
  - If mask!=0: s_axis_tready=slot_free. On accept:
    - the beat loads into the shared registers and m_axis_tvalid_i <= mask[i]
    - cur_mask <= mask
    - next state: SOP if tlast, else BODY
- State BODY:
  - s_axis_tready=slot_free; on accept, load the beat with m_axis_tvalid_i <= cur_mask[i].
  - tuser on later beats is passed through unchanged but not re-decoded.
  - tlast accepted -> SOP.
- State DROP: s_axis_tready=1; beats are discarded; tlast accepted -> SOP.
- Output drain:
  - m_axis_tvalid_i clears when m_axis_tready_i=1, unless a new beat loads in the same cycle that sets it again.
  - Each output drops its valid independently, so a multicast beat is never duplicated on a port that already took it.
- Latency: accepted beat appears on the selected outputs on the next cycle; throughput is 1 beat/cycle when every selected output is ready.
- The registered outputs must hold stable while valid and not ready. m_axis_tvalid_i never depends combinationally on m_axis_tready_i.
- s_axis_tready may depend combinationally on m_axis_tready_i.
- A packet with tlast on its first beat is a single-beat packet and is handled entirely in SOP.
- Reset mid-packet: the packet in flight is abandoned, including any output valids. After reset the next accepted beat is treated as a first beat.

Test Plan:
- 4-beat packet, tuser[26:24]=3'b010, all outputs ready -> 4 beats on output 1 only, cycles N+1..N+4, tlast on beat 4; outputs 0 and 2 stay invalid.
- 3-beat packet, mask 3'b101, m_axis_tready_2 held 0 for 5 cycles -> output 0 takes beat 1 at once; output 2 holds beat 1 stable; s_axis_tready=0 until output 2 accepts; each beat is delivered exactly once per port.
- 2-beat packet, mask 0 -> both beats accepted with s_axis_tready=1, no output valid, pkt_drop_count 0->1. Then a packet to 3'b001 is delivered normally.
- Back-to-back single-beat packets to masks 001, 010, 100, 111 with all outputs ready -> 1 beat/cycle; the correct valids on 4 consecutive cycles; no bubbles.
- Assert axi_reset during beat 2 of a 4-beat packet to output 0 -> all tvalid=0 immediately. The next packet's first beat (mask 3'b100) routes to output 2 only.
- Force pkt_drop_count to 0xFFFFFFFF, then one zero-mask packet -> the counter stays at 0xFFFFFFFF.
